// File: rtl/tow_pkg.sv
// tow_pkg
// Shared definitions for the tug-of-war controller: the game FSM state
// type, the rope position constants, the winner output encodings and a
// helper that turns a rope position into the one-hot playfield pattern.
package tow_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        WIN_L = 2'd1,
        WIN_R = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [3:0] CENTER_POS = 4'd4;
    localparam logic [3:0] MIN_POS    = 4'd0;
    localparam logic [3:0] MAX_POS    = 4'd8;

    localparam logic [1:0] WINNER_NONE  = 2'b00;
    localparam logic [1:0] WINNER_LEFT  = 2'b10;
    localparam logic [1:0] WINNER_RIGHT = 2'b01;

    // Bit 8 is the leftmost LED, so a higher position means the rope has
    // been pulled further towards the left player.
    function automatic logic [8:0] pos_to_leds(input logic [3:0] pos);
        logic [8:0] v;
        v = 9'd1 << pos;
        return v;
    endfunction

endpackage

// File: rtl/key_press.sv
// key_press
// Turns one raw, asynchronous push-button level into a single-cycle press
// pulse: two-flop synchronizer followed by a rising-edge detector.
//
// Ports:
//   i_clock  - system clock, rising edge active
//   i_reset  - asynchronous active-high reset
//   i_key    - raw key level, high = pressed, asynchronous to i_clock
//   o_pulse  - one-cycle pulse per press, decoded from registers only
module key_press (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_key,
    output logic o_pulse
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic       r_armed;
    logic [1:0] r_fill;

    // r_fill marks when r_sync2 holds a genuinely sampled key value rather
    // than its reset value. The detector is only armed once the key has
    // been seen released after reset, so a key held through reset does not
    // look like a fresh press when the synchronizer fills up.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_fill  <= 2'b00;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_fill  <= {r_fill[0], 1'b1};
            if (r_fill[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_pulse = r_sync2 & ~r_prev & r_armed;

endmodule

// File: rtl/tug_of_war_ctrl.sv
// tug_of_war_ctrl
// Two-player tug-of-war game. Each key press pulls the lit LED one step
// towards the presser; pulling it past the end wins the round, shows a
// pause with the winner flagged, then either restarts from the centre or
// ends the game once a player reaches WIN_SCORE rounds.
//
// Parameters:
//   PAUSE_CYCLES - length of the round-win pause in cycles (1..255)
//   WIN_SCORE    - rounds needed to win the game (1..7)
// Ports:
//   Clock     - system clock, rising edge active
//   reset     - asynchronous active-high reset
//   L, R      - raw left/right keys, asynchronous, high = pressed
//   leds      - playfield, bit 8 leftmost, one-hot while playing
//   score_l   - rounds won by the left player
//   score_r   - rounds won by the right player
//   winner    - 10 left, 01 right, 00 nobody
//   game_over - high once the game has ended
module tug_of_war_ctrl
    import tow_pkg::*;
#(
    parameter int PAUSE_CYCLES = 4,
    parameter int WIN_SCORE    = 7
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       L,
    input  logic       R,
    output logic [8:0] leds,
    output logic [2:0] score_l,
    output logic [2:0] score_r,
    output logic [1:0] winner,
    output logic       game_over
);

    // The counter is loaded with one less than the pause so that the FSM
    // leaves the pause on the edge where the counter reads zero, giving
    // exactly PAUSE_CYCLES cycles in WIN_L/WIN_R.
    localparam logic [7:0] PAUSE_LOAD = 8'(PAUSE_CYCLES - 1);
    localparam logic [2:0] WIN_LIMIT  = 3'(WIN_SCORE);

    state_t     r_state;
    logic [3:0] r_pos;
    logic [2:0] r_scoreL;
    logic [2:0] r_scoreR;
    logic [7:0] r_pauseCnt;

    state_t     w_nextState;
    logic [3:0] w_nextPos;
    logic [2:0] w_nextScoreL;
    logic [2:0] w_nextScoreR;
    logic [7:0] w_nextPauseCnt;

    logic       w_pulseL;
    logic       w_pulseR;
    logic       w_moveL;
    logic       w_moveR;
    logic [2:0] w_roundScore;

    key_press u_keyL (
        .i_clock (Clock),
        .i_reset (reset),
        .i_key   (L),
        .o_pulse (w_pulseL)
    );

    key_press u_keyR (
        .i_clock (Clock),
        .i_reset (reset),
        .i_key   (R),
        .o_pulse (w_pulseR)
    );

    // Simultaneous pulls cancel out.
    assign w_moveL = w_pulseL & ~w_pulseR;
    assign w_moveR = w_pulseR & ~w_pulseL;

    // Score of whichever side won the round currently being paused on.
    assign w_roundScore = (r_state == WIN_L) ? r_scoreL : r_scoreR;

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            r_state    <= PLAY;
            r_pos      <= CENTER_POS;
            r_scoreL   <= 3'd0;
            r_scoreR   <= 3'd0;
            r_pauseCnt <= 8'd0;
        end else begin
            r_state    <= w_nextState;
            r_pos      <= w_nextPos;
            r_scoreL   <= w_nextScoreL;
            r_scoreR   <= w_nextScoreR;
            r_pauseCnt <= w_nextPauseCnt;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_nextPos      = r_pos;
        w_nextScoreL   = r_scoreL;
        w_nextScoreR   = r_scoreR;
        w_nextPauseCnt = r_pauseCnt;

        case (r_state)
            PLAY: begin
                if (w_moveL) begin
                    if (r_pos == MAX_POS) begin
                        w_nextScoreL   = r_scoreL + 3'd1;
                        w_nextState    = WIN_L;
                        w_nextPauseCnt = PAUSE_LOAD;
                    end else begin
                        w_nextPos = r_pos + 4'd1;
                    end
                end else if (w_moveR) begin
                    if (r_pos == MIN_POS) begin
                        w_nextScoreR   = r_scoreR + 3'd1;
                        w_nextState    = WIN_R;
                        w_nextPauseCnt = PAUSE_LOAD;
                    end else begin
                        w_nextPos = r_pos - 4'd1;
                    end
                end
            end
            WIN_L, WIN_R: begin
                if (r_pauseCnt == 8'd0) begin
                    if (w_roundScore == WIN_LIMIT) begin
                        w_nextState = OVER;
                    end else begin
                        w_nextState = PLAY;
                        w_nextPos   = CENTER_POS;
                    end
                end else begin
                    w_nextPauseCnt = r_pauseCnt - 8'd1;
                end
            end
            OVER: begin
                w_nextState = OVER;
            end
            default: begin
                w_nextState = PLAY;
                w_nextPos   = CENTER_POS;
            end
        endcase
    end

    // In OVER the winner is whoever reached the winning score; both sides
    // can never reach it, since the game stops at the first one.
    always_comb begin
        winner = WINNER_NONE;
        case (r_state)
            WIN_L:   winner = WINNER_LEFT;
            WIN_R:   winner = WINNER_RIGHT;
            OVER:    winner = (r_scoreL == WIN_LIMIT) ? WINNER_LEFT : WINNER_RIGHT;
            default: winner = WINNER_NONE;
        endcase
    end

    assign leds      = (r_state == PLAY) ? pos_to_leds(r_pos) : 9'd0;
    assign score_l   = r_scoreL;
    assign score_r   = r_scoreR;
    assign game_over = (r_state == OVER);

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// tb_tug_of_war_ctrl
// Directed scenarios plus randomized key traffic for tug_of_war_ctrl. The
// random traffic is compared against a game-rule model that works from the
// key history (a press takes effect two edges after it is first sampled)
// and from the edge number at which a round pause ends.
module tb_tug_of_war_ctrl;

    localparam int PAUSE = 4;
    localparam int WINS  = 7;

    localparam int PH_PLAY  = 0;
    localparam int PH_LEFT  = 1;
    localparam int PH_RIGHT = 2;
    localparam int PH_DONE  = 3;

    localparam logic [17:0] RESET_OUT = {9'b000010000, 3'd0, 3'd0, 2'b00, 1'b0};

    logic       Clock = 1'b0;
    logic       reset = 1'b0;
    logic       L = 1'b0;
    logic       R = 1'b0;
    logic [8:0] leds;
    logic [2:0] score_l;
    logic [2:0] score_r;
    logic [1:0] winner;
    logic       game_over;

    logic [17:0] got;
    assign got = {leds, score_l, score_r, winner, game_over};

    int checks = 0;
    int errors = 0;

    int         mPos;
    int         mScoreL;
    int         mScoreR;
    int         mPhase;
    int         mEdge;
    int         mResumeAt;
    logic [3:0] mHistL;
    logic [3:0] mHistR;

    always #5 Clock = ~Clock;

    tug_of_war_ctrl #(
        .PAUSE_CYCLES (PAUSE),
        .WIN_SCORE    (WINS)
    ) dut (
        .Clock     (Clock),
        .reset     (reset),
        .L         (L),
        .R         (R),
        .leds      (leds),
        .score_l   (score_l),
        .score_r   (score_r),
        .winner    (winner),
        .game_over (game_over)
    );

    // Keys are treated as "already high" before reset release, so a press
    // needs a released-then-pressed sequence seen after reset.
    task automatic modelReset();
        mPos      = 4;
        mScoreL   = 0;
        mScoreR   = 0;
        mPhase    = PH_PLAY;
        mEdge     = 0;
        mResumeAt = 0;
        mHistL    = 4'b1111;
        mHistR    = 4'b1111;
    endtask

    task automatic modelEdge(input logic l, input logic r);
        logic pl;
        logic pr;
        mEdge  = mEdge + 1;
        mHistL = {mHistL[2:0], l};
        mHistR = {mHistR[2:0], r};
        pl = mHistL[2] && !mHistL[3];
        pr = mHistR[2] && !mHistR[3];
        if (mPhase == PH_PLAY) begin
            if (pl && !pr) begin
                if (mPos == 8) begin
                    mScoreL   = mScoreL + 1;
                    mPhase    = PH_LEFT;
                    mResumeAt = mEdge + PAUSE;
                end else begin
                    mPos = mPos + 1;
                end
            end else if (pr && !pl) begin
                if (mPos == 0) begin
                    mScoreR   = mScoreR + 1;
                    mPhase    = PH_RIGHT;
                    mResumeAt = mEdge + PAUSE;
                end else begin
                    mPos = mPos - 1;
                end
            end
        end else if (mPhase == PH_LEFT || mPhase == PH_RIGHT) begin
            if (mEdge == mResumeAt) begin
                if (((mPhase == PH_LEFT) ? mScoreL : mScoreR) == WINS) begin
                    mPhase = PH_DONE;
                end else begin
                    mPhase = PH_PLAY;
                    mPos   = 4;
                end
            end
        end
    endtask

    function automatic logic [17:0] modelOut();
        logic [8:0] l;
        logic [1:0] w;
        l = (mPhase == PH_PLAY) ? 9'(1 << mPos) : 9'd0;
        case (mPhase)
            PH_LEFT:  w = 2'b10;
            PH_RIGHT: w = 2'b01;
            PH_DONE:  w = (mScoreL == WINS) ? 2'b10 : 2'b01;
            default:  w = 2'b00;
        endcase
        return {l, 3'(mScoreL), 3'(mScoreR), w, (mPhase == PH_DONE)};
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick(input logic l, input logic r);
        L = l;
        R = r;
        @(posedge Clock);
        modelEdge(l, r);
        @(negedge Clock);
    endtask

    task automatic doReset(input logic holdL);
        L     = holdL;
        R     = 1'b0;
        reset = 1'b1;
        modelReset();
        @(negedge Clock);
        @(negedge Clock);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input int side, input int presses);
        for (int p = 0; p < presses; p++) begin
            tick(side == 0, side == 1);
            tick(side == 0, side == 1);
            tick(1'b0, 1'b0);
            tick(1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (got !== RESET_OUT) begin
            errors++;
            $display("[TB] FAIL reset_asserted got %h want %h", got, RESET_OUT);
        end
        doReset(1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (got !== RESET_OUT) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d got %h want %h", i, got, RESET_OUT);
            end
        end
    endtask

    task automatic test_single_move();
        logic [8:0] exp;
        doReset(1'b0);
        repeat (4) tick(1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, 1'b0);
            exp = (i >= 3) ? 9'b000100000 : 9'b000010000;
            checks++;
            if (leds !== exp) begin
                errors++;
                $display("[TB] FAIL single_move edge %0d leds got %b want %b", i, leds, exp);
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (leds !== 9'b000100000) begin
                errors++;
                $display("[TB] FAIL single_move_release leds got %b want %b", leds, 9'b000100000);
            end
        end
    endtask

    task automatic test_simultaneous();
        doReset(1'b0);
        repeat (4) tick(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(i < 6, i < 6);
            checks++;
            if (leds !== 9'b000010000) begin
                errors++;
                $display("[TB] FAIL simultaneous cycle %0d leds got %b want %b", i, leds, 9'b000010000);
            end
        end
    endtask

    task automatic test_left_win();
        logic [8:0] exp;
        doReset(1'b0);
        repeat (4) tick(1'b0, 1'b0);
        for (int p = 1; p <= 4; p++) begin
            applyStimulus(0, 1);
            exp = 9'(1 << (4 + p));
            checks++;
            if (leds !== exp) begin
                errors++;
                $display("[TB] FAIL left_move press %0d leds got %b want %b", p, leds, exp);
            end
        end
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        for (int c = 1; c <= PAUSE; c++) begin
            checks++;
            if (got !== {9'd0, 3'd1, 3'd0, 2'b10, 1'b0}) begin
                errors++;
                $display("[TB] FAIL left_pause cycle %0d got %h want %h", c, got,
                         {9'd0, 3'd1, 3'd0, 2'b10, 1'b0});
            end
            tick(c == 2, 1'b0);
        end
        checks++;
        if (got !== {9'b000010000, 3'd1, 3'd0, 2'b00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL left_resume got %h want %h", got,
                     {9'b000010000, 3'd1, 3'd0, 2'b00, 1'b0});
        end
    endtask

    task automatic test_game_over();
        doReset(1'b0);
        repeat (4) tick(1'b0, 1'b0);
        for (int round = 1; round <= WINS; round++) begin
            applyStimulus(1, 5);
            repeat (4) tick(1'b0, 1'b0);
            checks++;
            if (round < WINS) begin
                if (got !== {9'b000010000, 3'd0, 3'(round), 2'b00, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL right_round %0d got %h want %h", round, got,
                             {9'b000010000, 3'd0, 3'(round), 2'b00, 1'b0});
                end
            end else begin
                if (got !== {9'd0, 3'd0, 3'd7, 2'b01, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL game_over got %h want %h", got,
                             {9'd0, 3'd0, 3'd7, 2'b01, 1'b1});
                end
            end
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if (got !== {9'd0, 3'd0, 3'd7, 2'b01, 1'b1}) begin
                errors++;
                $display("[TB] FAIL over_hold cycle %0d got %h want %h", i, got,
                         {9'd0, 3'd0, 3'd7, 2'b01, 1'b1});
            end
        end
        L = 1'b0;
        R = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (got !== RESET_OUT) begin
            errors++;
            $display("[TB] FAIL reset_in_over got %h want %h", got, RESET_OUT);
        end
        @(negedge Clock);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic test_reset_during_pause();
        doReset(1'b0);
        repeat (4) tick(1'b0, 1'b0);
        applyStimulus(0, 4);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if (winner !== 2'b10) begin
            errors++;
            $display("[TB] FAIL pause_entry winner got %b want %b", winner, 2'b10);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (got !== RESET_OUT) begin
            errors++;
            $display("[TB] FAIL reset_in_pause got %h want %h", got, RESET_OUT);
        end
        @(negedge Clock);
        reset = 1'b0;
        modelReset();
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (got !== RESET_OUT) begin
                errors++;
                $display("[TB] FAIL pause_abandoned cycle %0d got %h want %h", i, got, RESET_OUT);
            end
        end
    endtask

    task automatic test_held_through_reset();
        doReset(1'b1);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (leds !== 9'b000010000) begin
                errors++;
                $display("[TB] FAIL held_reset cycle %0d leds got %b want %b", i, leds, 9'b000010000);
            end
        end
        repeat (3) tick(1'b0, 1'b0);
        applyStimulus(0, 1);
        checks++;
        if (leds !== 9'b000100000) begin
            errors++;
            $display("[TB] FAIL held_reset_press leds got %b want %b", leds, 9'b000100000);
        end
    endtask

    task automatic test_random();
        logic lk;
        logic rk;
        logic favourL;
        logic [17:0] exp;
        for (int run = 0; run < 3; run++) begin
            doReset(1'b0);
            lk = 1'b0;
            rk = 1'b0;
            for (int t = 0; t < 500; t++) begin
                favourL = (((t / 40) % 2) == 0) ^ (run == 1);
                if ($urandom_range(0, favourL ? 1 : 7) == 0) lk = ~lk;
                if ($urandom_range(0, favourL ? 7 : 1) == 0) rk = ~rk;
                tick(lk, rk);
                exp = modelOut();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("[TB] FAIL random run %0d cycle %0d got %h want %h", run, t, got, exp);
                end
            end
        end
    endtask

    initial begin
        modelReset();
        @(negedge Clock);
        test_reset();
        test_single_move();
        test_simultaneous();
        test_left_win();
        test_game_over();
        test_reset_during_pause();
        test_held_through_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tug_of_war_ctrl.md
TUG_OF_WAR_CTRL -- requirements
Module: tug_of_war_ctrl

Interface
REQ-001 SHALL have parameter PAUSE_CYCLES, default 4, meaning the number of cycles the round-win pause lasts (legal range 1..255).
REQ-002 SHALL have parameter WIN_SCORE, default 7, meaning the round count that ends the game (legal range 1..7).
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port L, input, 1 bit: raw left-player key, asynchronous to Clock, level high = pressed.
REQ-006 SHALL have port R, input, 1 bit: raw right-player key, same properties as L.
REQ-007 SHALL have port leds, output, 9 bits: playfield; bit 8 = leftmost, bit 4 = centre.
REQ-008 SHALL have port score_l, output, 3 bits: left rounds won, unsigned.
REQ-009 SHALL have port score_r, output, 3 bits: right rounds won, unsigned.
REQ-010 SHALL have port winner, output, 2 bits: 00 none, 10 left, 01 right; 11 never driven.
REQ-011 SHALL have port game_over, output, 1 bit: high while in state OVER.

Function
REQ-012 SHALL pass each key through a two-flop synchronizer, then a rising-edge detector, giving a one-cycle press pulse per key press.
REQ-013 SHALL limit each press pulse to one cycle per key press regardless of hold length; a held key SHALL produce no further pulses.
REQ-014 SHALL hold a position register pos (0..8, reset 4); in PLAY, leds SHALL be one-hot with bit pos set.
REQ-015 SHALL, in PLAY, on a left pulse alone with pos<8, set pos to pos+1; on a right pulse alone with pos>0, set pos to pos-1.
REQ-016 SHALL leave pos unchanged when both pulses occur in the same cycle.
REQ-017 SHALL, in PLAY with pos=8 and a left pulse alone, increment score_l, go to WIN_L and load the pause counter.
REQ-018 SHALL, in PLAY with pos=0 and a right pulse alone, increment score_r, go to WIN_R and load the pause counter.
REQ-019 SHALL use FSM states PLAY, WIN_L, WIN_R and OVER.
REQ-020 SHALL, in WIN_L/WIN_R, drive leds all zero, drive winner to 10/01, and ignore press pulses.
REQ-021 SHALL, when leaving WIN_x after exactly PAUSE_CYCLES cycles, go to OVER if that side's score equals WIN_SCORE, else go to PLAY with pos=4 and winner=00.
REQ-022 SHALL, in OVER, drive leds=0, hold winner and both scores, ignore all presses and remain there until reset.
REQ-023 SHALL update leds at the third rising edge at which the key is sampled high, counting the first such edge as one; this is the press-to-leds latency.
REQ-024 SHALL drive all outputs directly from registers or from decode of registered state only, with no combinational path from L/R.
REQ-025 SHALL never wrap score counters, since OVER is entered at WIN_SCORE.

Reset
REQ-026 SHALL, on reset assertion, immediately and asynchronously set: state PLAY, pos=4, leds=000010000, score_l=0, score_r=0, winner=00, game_over=0.
REQ-027 SHALL also clear synchronizer, edge-detector and pause-counter flops on reset.
REQ-028 SHALL NOT produce a press pulse on the first cycles after reset deassertion when a key is held through reset.
REQ-029 SHALL, on reset asserted mid-pause or in OVER, abandon the round with no score retained.

Structure
REQ-030 SHALL place the state enum (PLAY, WIN_L, WIN_R, OVER), the CENTER_POS=4 constant and the winner encodings in shared package tow_pkg.
REQ-031 SHALL implement the synchronizer plus edge detector as sub-module key_press, instantiated once per key.

Verification
REQ-032 SHALL check reset: after reset release, leds=000010000, scores=0, winner=00, game_over=0.
REQ-033 SHALL check single move: L held high for 10 cycles -> leds become 000100000 at the third edge, then stay there (one move only).
REQ-034 SHALL check simultaneous presses: L and R rise in the same cycle -> leds stay 000010000.
REQ-035 SHALL check a left round win: 5 separate L presses -> score_l=1, winner=10 and leds=0 for 4 cycles, then leds=000010000 and winner=00.
REQ-036 SHALL check game end: right wins 7 rounds -> score_r=7, game_over=1, winner=01 held, and further presses are ignored.
REQ-037 SHALL check reset during pause: reset asserted during WIN_L pause cycle 2 -> all outputs return to their reset values asynchronously.
